// File: rtl/vector_processor_if.sv
// Shader <-> vector-processor command/result bundle.
// The shader pipeline is the master (drives start/operation/operands).
// The vector processor is the slave (returns busy/done/result/op_error).
interface vector_processor_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int VECTOR_WIDTH = 4
);
  logic                               start;
  logic [3:0]                         operation;
  logic [VECTOR_WIDTH*DATA_WIDTH-1:0] vec_a;
  logic [VECTOR_WIDTH*DATA_WIDTH-1:0] vec_b;
  logic [DATA_WIDTH-1:0]              scalar;
  logic                               busy;
  logic                               done;
  logic [VECTOR_WIDTH*DATA_WIDTH-1:0] result;
  logic                               result_valid;
  logic                               op_error;

  modport master (
    output start, operation, vec_a, vec_b, scalar,
    input  busy, done, result, result_valid, op_error
  );

  modport slave (
    input  start, operation, vec_a, vec_b, scalar,
    output busy, done, result, result_valid, op_error
  );
endinterface

// File: rtl/vector_processor.sv
// Purpose: 8.8 fixed-point vector unit (PASS/ADD/SUB/MUL/SCALE/LENGTH/DOT); VECTOR_SAT_EN selects saturating MUL/SCALE/DOT.
// Latency: start at edge E0 -> done/result_valid after E2 (LENGTH: after E18, 16-step restoring sqrt).
// Backpressure: none; start is taken only in IDLE, starts while busy or in the DONE cycle are dropped.
module vector_processor #(
  parameter int DATA_WIDTH   = 16,
  parameter int VECTOR_WIDTH = 4,
  parameter int FRAC_BITS    = 8
) (
  input logic               clk,
  input logic               rst,
  vector_processor_if.slave bus
);

  localparam int VW  = VECTOR_WIDTH * DATA_WIDTH;          // packed vector width
  localparam int PW  = 2 * DATA_WIDTH;                     // full product / square width
  localparam int SW  = PW + $clog2(VECTOR_WIDTH);          // sum of squares width
  localparam int DSW = DATA_WIDTH + $clog2(VECTOR_WIDTH);  // dot-product sum width
  localparam int RW  = DATA_WIDTH + 2;                     // sqrt remainder width
  localparam int CW  = $clog2(DATA_WIDTH);                 // sqrt iteration counter width

  localparam logic [3:0] OP_PASS   = 4'd0;
  localparam logic [3:0] OP_ADD    = 4'd1;
  localparam logic [3:0] OP_SUB    = 4'd2;
  localparam logic [3:0] OP_MUL    = 4'd3;
  localparam logic [3:0] OP_SCALE  = 4'd4;
  localparam logic [3:0] OP_LENGTH = 4'd5;
  localparam logic [3:0] OP_DOT    = 4'd6;

  localparam logic [DATA_WIDTH-1:0] ALL_ONES = {DATA_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_SQRT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Latched command
  logic [3:0]            op_q;
  logic [VW-1:0]         a_q;
  logic [VW-1:0]         b_q;
  logic [DATA_WIDTH-1:0] scalar_q;

  // Square-root engine
  logic [PW-1:0]         rad_q;
  logic [RW-1:0]         rem_q;
  logic [DATA_WIDTH-1:0] root_q;
  logic [CW-1:0]         cnt_q;
  logic                  len_ovf_q;

  // Registered outputs
  logic [VW-1:0]         result_q;
  logic                  done_q;
  logic                  op_err_q;

  // Per-element datapath
  logic [DATA_WIDTH-1:0] ea       [VECTOR_WIDTH];
  logic [DATA_WIDTH-1:0] eb       [VECTOR_WIDTH];
  logic [DATA_WIDTH-1:0] abs_e    [VECTOR_WIDTH];
  logic [PW-1:0]         prod_mul [VECTOR_WIDTH];
  logic [PW-1:0]         prod_scl [VECTOR_WIDTH];
  logic [PW-1:0]         sq       [VECTOR_WIDTH];
  logic [VW-1:0]         add_vec, sub_vec, mul_vec, scl_vec;
  logic [SW-1:0]         sq_sum;
  logic [DSW-1:0]        dot_sum;
  logic [DATA_WIDTH-1:0] dot_val;

  // Sqrt step and result selection
  logic [RW+1:0]         rem_shift;
  logic [RW+1:0]         trial;
  logic                  root_bit;
  logic [RW-1:0]         rem_nxt;
  logic [VW-1:0]         res_d;
  logic                  err_d;
  logic                  unused_fold;

  // Slice latched operands into elements (element 0 at the MSBs) and form all element-wise results.
  always_comb begin
    add_vec = '0;
    sub_vec = '0;
    mul_vec = '0;
    scl_vec = '0;
    sq_sum  = '0;
    dot_sum = '0;
    for (int i = 0; i < VECTOR_WIDTH; i++) begin
      ea[i]       = a_q[(VECTOR_WIDTH-1-i)*DATA_WIDTH +: DATA_WIDTH];
      eb[i]       = b_q[(VECTOR_WIDTH-1-i)*DATA_WIDTH +: DATA_WIDTH];
      prod_mul[i] = PW'(ea[i]) * PW'(eb[i]);
      prod_scl[i] = PW'(ea[i]) * PW'(scalar_q);
      // Two's-complement magnitude; the most negative value maps onto itself, read as unsigned.
      abs_e[i]    = ea[i][DATA_WIDTH-1] ? DATA_WIDTH'(~ea[i] + 1'b1) : ea[i];
      sq[i]       = PW'(abs_e[i]) * PW'(abs_e[i]);
      sq_sum      = sq_sum + SW'(sq[i]);
      dot_sum     = dot_sum + DSW'(prod_mul[i][FRAC_BITS +: DATA_WIDTH]);
      add_vec[(VECTOR_WIDTH-1-i)*DATA_WIDTH +: DATA_WIDTH] = ea[i] + eb[i];
      sub_vec[(VECTOR_WIDTH-1-i)*DATA_WIDTH +: DATA_WIDTH] = ea[i] - eb[i];
`ifdef VECTOR_SAT_EN
      mul_vec[(VECTOR_WIDTH-1-i)*DATA_WIDTH +: DATA_WIDTH] =
        (|prod_mul[i][PW-1:DATA_WIDTH+FRAC_BITS]) ? ALL_ONES : prod_mul[i][FRAC_BITS +: DATA_WIDTH];
      scl_vec[(VECTOR_WIDTH-1-i)*DATA_WIDTH +: DATA_WIDTH] =
        (|prod_scl[i][PW-1:DATA_WIDTH+FRAC_BITS]) ? ALL_ONES : prod_scl[i][FRAC_BITS +: DATA_WIDTH];
`else
      mul_vec[(VECTOR_WIDTH-1-i)*DATA_WIDTH +: DATA_WIDTH] = prod_mul[i][FRAC_BITS +: DATA_WIDTH];
      scl_vec[(VECTOR_WIDTH-1-i)*DATA_WIDTH +: DATA_WIDTH] = prod_scl[i][FRAC_BITS +: DATA_WIDTH];
`endif
    end
`ifdef VECTOR_SAT_EN
    dot_val = (|dot_sum[DSW-1:DATA_WIDTH]) ? ALL_ONES : dot_sum[DATA_WIDTH-1:0];
`else
    dot_val = dot_sum[DATA_WIDTH-1:0];
`endif
  end

  // Product bits below the 8.8 window (and the overflow bits in the wrap build) are intentionally dropped.
  always_comb begin
    unused_fold = ^dot_sum;
    for (int i = 0; i < VECTOR_WIDTH; i++) begin
      unused_fold = unused_fold ^ (^prod_mul[i]) ^ (^prod_scl[i]);
    end
  end

  // One restoring square-root step: bring down two radicand bits, try subtracting (4*root + 1).
  always_comb begin
    rem_shift = {rem_q, rad_q[PW-1 -: 2]};
    trial     = {2'b00, root_q, 2'b01};
    root_bit  = (rem_shift >= trial);
    rem_nxt   = root_bit ? RW'(rem_shift - trial) : RW'(rem_shift);
  end

  // Pick the value that will be registered as the result in the DONE cycle.
  always_comb begin
    res_d = a_q;
    err_d = 1'b0;
    case (op_q)
      OP_PASS:   res_d = a_q;
      OP_ADD:    res_d = add_vec;
      OP_SUB:    res_d = sub_vec;
      OP_MUL:    res_d = mul_vec;
      OP_SCALE:  res_d = scl_vec;
      OP_LENGTH: begin
        res_d = '0;
        // A sum of squares beyond the 32-bit radicand clamps in every build.
        res_d[VW-1 -: DATA_WIDTH] = len_ovf_q ? ALL_ONES : root_q;
      end
      OP_DOT: begin
        res_d = '0;
        res_d[VW-1 -: DATA_WIDTH] = dot_val;
      end
      default: begin
        res_d = a_q;
        err_d = 1'b1;
      end
    endcase
  end

  // Next-state: IDLE -> EXEC -> (SQRT for LENGTH) -> DONE -> IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_EXEC;
      S_EXEC: state_d = (op_q == OP_LENGTH) ? S_SQRT : S_DONE;
      S_SQRT: if (cnt_q == CW'(DATA_WIDTH-1)) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset abandons any command in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command latch, sqrt iteration and registered result/pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      scalar_q  <= '0;
      rad_q     <= '0;
      rem_q     <= '0;
      root_q    <= '0;
      cnt_q     <= '0;
      len_ovf_q <= 1'b0;
      result_q  <= '0;
      done_q    <= 1'b0;
      op_err_q  <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      op_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            op_q     <= bus.operation;
            a_q      <= bus.vec_a;
            b_q      <= bus.vec_b;
            scalar_q <= bus.scalar;
          end
        end
        S_EXEC: begin
          // Squares are summed once here; the sqrt engine then runs on the low 32 bits.
          rad_q     <= sq_sum[PW-1:0];
          len_ovf_q <= |sq_sum[SW-1:PW];
          rem_q     <= '0;
          root_q    <= '0;
          cnt_q     <= '0;
        end
        S_SQRT: begin
          rem_q  <= rem_nxt;
          root_q <= {root_q[DATA_WIDTH-2:0], root_bit};
          rad_q  <= rad_q << 2;
          cnt_q  <= cnt_q + 1'b1;
        end
        S_DONE: begin
          result_q <= res_d;
          done_q   <= 1'b1;
          op_err_q <= err_d;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy         = (state_q == S_EXEC) || (state_q == S_SQRT);
  assign bus.done         = done_q;
  assign bus.result_valid = done_q;
  assign bus.op_error     = op_err_q;
  assign bus.result       = result_q;

endmodule
